// File: rtl/uart_txd.sv
// uart_txd: 8N1 UART transmitter, LSB first, with a one-byte holding register
// so back-to-back frames leave no idle gap on the line.
// Optional even-parity bit after data bit 7: define UART_TXD_PARITY_EN.
module uart_txd #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_from_cipher,
  input  logic       txd_start,
  output logic       txd_ready,
  output logic       txd_data_out,
  output logic       txd_busy,
  output logic       txd_done
);

  localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TXD_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_hold, w_hold_nxt;
  logic          r_hold_full, w_hold_full_nxt;
  logic          r_txd, w_txd_nxt;
  logic          r_done, w_done_nxt;
`ifdef UART_TXD_PARITY_EN
  logic          r_parity, w_parity_nxt;
`endif

  logic       w_accept;
  logic       w_baud_last;
  logic       w_load_opp;
  logic       w_load;
  logic [7:0] w_load_byte;

  assign w_accept    = txd_start && !r_hold_full;
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_load_opp  = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_last);
  // A pending held byte takes priority; otherwise an accept in a load slot bypasses hold.
  assign w_load      = w_load_opp && (r_hold_full || w_accept);
  assign w_load_byte = r_hold_full ? r_hold : data_from_cipher;

  // Next-state, bit timing, holding register and next line value.
  always_comb begin
    w_state_nxt     = r_state;
    w_baud_nxt      = r_baud;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_txd_nxt       = 1'b1;
    w_done_nxt      = 1'b0;
`ifdef UART_TXD_PARITY_EN
    w_parity_nxt    = r_parity;
`endif

    if (r_state != ST_IDLE) begin
      w_baud_nxt = w_baud_last ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      ST_IDLE: ;
      ST_START: begin
        if (w_baud_last) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_baud_last) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TXD_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TXD_PARITY_EN
      ST_PARITY: begin
        if (w_baud_last) w_state_nxt = ST_PARITY == ST_PARITY ? ST_STOP : ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_baud_last) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = '0;
      end
    endcase

    if (w_load) begin
      w_state_nxt   = ST_START;
      w_shift_nxt   = w_load_byte;
      w_bit_idx_nxt = '0;
      w_baud_nxt    = '0;
`ifdef UART_TXD_PARITY_EN
      w_parity_nxt  = ^w_load_byte;
`endif
    end

    if (w_load && r_hold_full) begin
      w_hold_full_nxt = 1'b0;
    end else if (w_accept && !w_load) begin
      w_hold_full_nxt = 1'b1;
      w_hold_nxt      = data_from_cipher;
    end

    // Line and done are registered from next-state values so they align with the state.
    case (w_state_nxt)
      ST_START:  w_txd_nxt = 1'b0;
      ST_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TXD_PARITY_EN
      ST_PARITY: w_txd_nxt = w_parity_nxt;
`endif
      default:   w_txd_nxt = 1'b1;
    endcase
    w_done_nxt = (w_state_nxt == ST_STOP) && (w_baud_nxt == BAUD_LAST);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_txd       <= 1'b1;
      r_done      <= 1'b0;
`ifdef UART_TXD_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_baud      <= w_baud_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_txd       <= w_txd_nxt;
      r_done      <= w_done_nxt;
`ifdef UART_TXD_PARITY_EN
      r_parity    <= w_parity_nxt;
`endif
    end
  end

  assign txd_ready    = !r_hold_full;
  assign txd_data_out = r_txd;
  assign txd_busy     = (r_state != ST_IDLE);
  assign txd_done     = r_done;

endmodule

// File: tb/tb_uart_txd.sv
// tb_uart_txd: randomized bench for uart_txd against a frame-level reference
// model (frame start times plus bit arithmetic) and a mid-bit sampling receiver.
module tb_uart_txd;

  localparam int CPB = 16;
`ifdef UART_TXD_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_from_cipher = '0;
  logic       txd_start = 1'b0;
  logic       txd_ready;
  logic       txd_data_out;
  logic       txd_busy;
  logic       txd_done;

  uart_txd #(.CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_from_cipher (data_from_cipher),
    .txd_start        (txd_start),
    .txd_ready        (txd_ready),
    .txd_data_out     (txd_data_out),
    .txd_busy         (txd_busy),
    .txd_done         (txd_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  // Reference model: current frame (start cycle + byte) and one held byte.
  bit         m_active    = 1'b0;
  int         m_s         = 0;
  logic [7:0] m_byte      = '0;
  bit         m_hold_full = 1'b0;
  logic [7:0] m_hold      = '0;
  logic [7:0] exp_q[$];

  // Receiver model.
  bit         rx_active = 1'b0;
  int         rx_t0     = 0;
  logic [7:0] rx_byte   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic exp_line();
    int o;
    int b;
    if (!m_active) return 1'b1;
    o = t - m_s;
    b = o / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
`ifdef UART_TXD_PARITY_EN
    if (b == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  task automatic rx_step();
    int o;
    int k;
    logic ln;
    logic [7:0] e;
    ln = txd_data_out;
    if (!rx_active) begin
      if (ln == 1'b0) begin
        rx_active = 1'b1;
        rx_t0     = t;
        rx_byte   = '0;
      end
    end else begin
      o = t - rx_t0;
      if (o % CPB == CPB / 2) begin
        k = o / CPB;
        if (k >= 1 && k <= 8) rx_byte[k-1] = ln;
`ifdef UART_TXD_PARITY_EN
        if (k == 9) chk("rx_parity", 32'(ln), 32'(^rx_byte));
`endif
        if (k == NBITS - 1) begin
          chk("rx_stop", 32'(ln), 32'd1);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          chk("rx_byte", 32'(rx_byte), {24'd0, e});
          rx_active = 1'b0;
        end
      end
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    m_active = 1'b1;
    m_s      = t + 1;
    m_byte   = b;
    exp_q.push_back(b);
  endtask

  task automatic model_advance(input logic st, input logic [7:0] d, input logic rn);
    bit acc;
    bit last;
    bit opp;
    if (!rn) begin
      m_active    = 1'b0;
      m_hold_full = 1'b0;
      rx_active   = 1'b0;
      exp_q.delete();
    end else begin
      acc  = st && !m_hold_full;
      last = m_active && (t - m_s == FLEN - 1);
      opp  = !m_active || last;
      if (opp && m_hold_full) begin
        start_frame(m_hold);
        m_hold_full = 1'b0;
      end else if (opp && acc) begin
        start_frame(d);
      end else begin
        if (acc) begin
          m_hold_full = 1'b1;
          m_hold      = d;
        end
        if (last) m_active = 1'b0;
      end
    end
  endtask

  // One clock: check outputs of the current cycle, drive inputs, advance the model.
  task automatic cycle(input logic st, input logic [7:0] d, input logic rn);
    chk("txd_data_out", 32'(txd_data_out), 32'(exp_line()));
    chk("txd_busy",     32'(txd_busy),     32'(m_active));
    chk("txd_ready",    32'(txd_ready),    32'(!m_hold_full));
    chk("txd_done",     32'(txd_done),     32'(m_active && (t - m_s == FLEN - 1)));
    rx_step();
    txd_start        = st;
    data_from_cipher = d;
    rst              = rn;
    model_advance(st, d, rn);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held low for three cycles.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    idle(5);

    // Single byte from idle.
    cycle(1'b1, 8'hA5, 1'b1);
    idle(FLEN + 20);
`ifdef UART_TXD_PARITY_EN
    cycle(1'b1, 8'h01, 1'b1);
    idle(FLEN + 20);
`endif

    // Back-to-back with an overflow attempt while hold is full.
    cycle(1'b1, 8'h3C, 1'b1);
    idle(40);
    cycle(1'b1, 8'hC3, 1'b1);
    idle(3);
    cycle(1'b1, 8'hFF, 1'b1);
    idle(2 * FLEN + 20);

    // Reset during data bit 3, then a clean frame.
    cycle(1'b1, 8'h55, 1'b1);
    idle(4 * CPB + 6);
    cycle(1'b0, 8'h00, 1'b0);
    idle(5);
    cycle(1'b1, 8'h0F, 1'b1);
    idle(FLEN + 20);

    // Sparse random traffic with rare resets.
    for (int i = 0; i < 20000; i++) begin
      cycle(($urandom_range(0, 29) == 0), 8'($urandom), ($urandom_range(0, 7999) != 0));
    end
    // Saturated traffic: txd_start held high.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1);
    end
    idle(2 * FLEN + 20);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
